// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and size decode for the load/store unit
package lsu_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WRITE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        ERR    = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_BAD = 2'd3
    } size_e;

    // Access size of a request; unsigned variants exist only for loads
    function automatic size_e lsu_size(input logic [2:0] f3, input logic we);
        size_e sz;
        case (f3)
            F3_B:    sz = SZ_B;
            F3_H:    sz = SZ_H;
            F3_W:    sz = SZ_W;
            F3_BU:   sz = we ? SZ_BAD : SZ_B;
            F3_HU:   sz = we ? SZ_BAD : SZ_H;
            default: sz = SZ_BAD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// rtl/lsu_byte_lane.sv - load extract/extend and sub-word store merge
module lsu_byte_lane
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merge_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed byte/half out of the memory word and extend it
    always_comb begin
        lane_b    = word[{offset, 3'b000} +: 8];
        lane_h    = word[{offset[1], 4'b0000} +: 16];
        load_data = word;
        case (funct3)
            F3_B:    load_data = {{(XLEN-8){lane_b[7]}}, lane_b};
            F3_BU:   load_data = {{(XLEN-8){1'b0}}, lane_b};
            F3_H:    load_data = {{(XLEN-16){lane_h[15]}}, lane_h};
            F3_HU:   load_data = {{(XLEN-16){1'b0}}, lane_h};
            default: load_data = word;
        endcase
    end

    // Overwrite only the target lane(s) of the old word with store data
    always_comb begin
        merge_data = word;
        case (funct3)
            F3_B:    merge_data[{offset, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    merge_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// rtl/lsu_mem_if.sv - load/store unit in front of a word-wide data memory
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int MEM_AW = 10,
    parameter int XLEN   = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [2:0]        lsu_funct3_i,
    input  logic [XLEN-1:0]   lsu_addr_i,
    input  logic [XLEN-1:0]   lsu_wdata_i,
    output logic              lsu_ready_o,
    output logic              lsu_rvalid_o,
    output logic [XLEN-1:0]   lsu_rdata_o,
    output logic              lsu_done_o,
    output logic              lsu_err_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic              mem_wren_o,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    state_e            state_q, state_d;
    logic [2:0]        req_f3;
    logic [MEM_AW+1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [XLEN-1:0]   merge_q;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   merge_data;

    size_e sz;
    logic  range_err;
    logic  align_err;
    logic  req_err;
    logic  accept;

    assign accept    = lsu_req_i && lsu_ready_o;
    assign sz        = lsu_size(lsu_funct3_i, lsu_we_i);
    assign range_err = |lsu_addr_i[XLEN-1:MEM_AW+2];
    assign align_err = (sz == SZ_H && lsu_addr_i[0]) ||
                       (sz == SZ_W && lsu_addr_i[1:0] != 2'b00);
    assign req_err   = (sz == SZ_BAD) || range_err || align_err;

    // Word address always comes from the latched request
    assign mem_addr_o = req_addr[MEM_AW+1:2];

    lsu_byte_lane #(.XLEN(XLEN)) u_lane (
        .word       (mem_rdata_i),
        .offset     (req_addr[1:0]),
        .funct3     (req_f3),
        .wdata      (req_wdata),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: route accepted requests, every other state lasts one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (lsu_req_i) begin
                    if (req_err)        state_d = ERR;
                    else if (!lsu_we_i) state_d = LOAD;
                    else if (sz == SZ_W) state_d = WRITE;
                    else                state_d = RMW_RD;
                end
            end
            LOAD:    state_d = IDLE;
            WRITE:   state_d = IDLE;
            RMW_RD:  state_d = RMW_WR;
            RMW_WR:  state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state so the write enable drops at once on reset
    always_comb begin
        lsu_ready_o = (state_q == IDLE);
        mem_wren_o  = 1'b0;
        mem_wdata_o = '0;
        case (state_q)
            WRITE: begin
                mem_wren_o  = 1'b1;
                mem_wdata_o = req_wdata;
            end
            RMW_WR: begin
                mem_wren_o  = 1'b1;
                mem_wdata_o = merge_q;
            end
            default: ;
        endcase
    end

    // Capture the request fields when it is accepted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_f3    <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else if (accept) begin
            req_f3    <= lsu_funct3_i;
            req_addr  <= lsu_addr_i[MEM_AW+1:0];
            req_wdata <= lsu_wdata_i;
        end
    end

    // Response pulses, load data and the read-modify-write merge word
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lsu_rvalid_o <= 1'b0;
            lsu_done_o   <= 1'b0;
            lsu_err_o    <= 1'b0;
            lsu_rdata_o  <= '0;
            merge_q      <= '0;
        end else begin
            lsu_rvalid_o <= (state_q == LOAD);
            lsu_done_o   <= (state_q == WRITE) || (state_q == RMW_WR);
            lsu_err_o    <= (state_q == ERR);
            if (state_q == LOAD) begin
                lsu_rdata_o <= load_data;
            end
            if (state_q == RMW_RD) begin
                merge_q <= merge_data;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// tb/tb_lsu_mem_if.sv - scoreboard bench for lsu_mem_if
module tb_lsu_mem_if;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wren;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    logic [31:0] exp_last = 32'h0;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
        int          cyc;
    } wr_t;

    rsp_t rq[$];
    wr_t  wq[$];

    lsu_mem_if #(.MEM_AW(10), .XLEN(32)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .lsu_req_i    (req),
        .lsu_we_i     (we),
        .lsu_funct3_i (f3),
        .lsu_addr_i   (addr),
        .lsu_wdata_i  (wdata),
        .lsu_ready_o  (ready),
        .lsu_rvalid_o (rvalid),
        .lsu_rdata_o  (rdata),
        .lsu_done_o   (done),
        .lsu_err_o    (err),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_wren_o   (mem_wren),
        .mem_rdata_i  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = rst_n ? mem[mem_addr] : 32'h0;

    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_wdata;
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: pops one expectation per pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (rvalid || done || err) begin
                int k;
                k = rvalid ? 0 : (done ? 1 : 2);
                chk("single_pulse", {29'b0, rvalid, done, err} == 32'd1 ||
                    {29'b0, rvalid, done, err} == 32'd2 ||
                    {29'b0, rvalid, done, err} == 32'd4, 1'b1);
                if (rq.size() == 0) begin
                    chk("unexpected_rsp", 32'(k), 32'hFFFF_FFFF);
                end else begin
                    rsp_t e;
                    e = rq.pop_front();
                    chk("rsp_kind", 32'(k), 32'(e.kind));
                    chk("rsp_rdata", rdata, e.data);
                    chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (mem_wren) begin
                if (wq.size() == 0) begin
                    chk("unexpected_wren", {22'b0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_addr", {22'b0, mem_addr}, {22'b0, w.a});
                    chk("wr_data", mem_wdata, w.d);
                    chk("wr_cycle", 32'(cyc), 32'(w.cyc));
                end
            end
        end
    end

    // Present a request at a negedge, wait for ready, queue expectations
    task automatic issue(input logic i_we, input logic [2:0] i_f3, input logic [31:0] i_addr,
                         input logic [31:0] i_wd, input int kind, input int lat,
                         input logic [31:0] rexp, input logic wr, input logic [31:0] wexp,
                         input int wlat);
        int n;
        req   = 1'b1;
        we    = i_we;
        f3    = i_f3;
        addr  = i_addr;
        wdata = i_wd;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            chk("accept_timeout", 32'(n), 32'd0);
        end else begin
            last_acc = cyc;
            rq.push_back('{kind, rexp, cyc + lat});
            if (wr) wq.push_back('{i_addr[11:2], wexp, cyc + wlat});
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic do_load(input logic [2:0] i_f3, input logic [31:0] i_addr, input logic [31:0] exp);
        exp_last = exp;
        issue(1'b0, i_f3, i_addr, 32'h0, 0, 2, exp, 1'b0, 32'h0, 0);
    endtask

    task automatic do_sw(input logic [31:0] i_addr, input logic [31:0] d);
        issue(1'b1, 3'b010, i_addr, d, 1, 2, exp_last, 1'b1, d, 1);
    endtask

    task automatic do_sub(input logic [2:0] i_f3, input logic [31:0] i_addr,
                          input logic [31:0] d, input logic [31:0] merged);
        issue(1'b1, i_f3, i_addr, d, 1, 3, exp_last, 1'b1, merged, 2);
    endtask

    task automatic do_err(input logic i_we, input logic [2:0] i_f3, input logic [31:0] i_addr);
        issue(i_we, i_f3, i_addr, 32'h5555_5555, 2, 2, exp_last, 1'b0, 32'h0, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("drain_rsp_q", 32'(rq.size()), 32'd0);
        chk("drain_wr_q", 32'(wq.size()), 32'd0);
    endtask

    initial begin
        int sw_acc;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[3] = 32'h8BAD_F00D;
        rst_n = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        f3    = 3'b000;
        addr  = 32'h0;
        wdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_wren", {31'b0, mem_wren}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_addr", {22'b0, mem_addr}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_load(3'b010, 32'h0000_000C, 32'h8BAD_F00D);
        do_load(3'b000, 32'h0000_000F, 32'hFFFF_FF8B);
        do_load(3'b100, 32'h0000_000F, 32'h0000_008B);
        do_load(3'b001, 32'h0000_000E, 32'hFFFF_8BAD);
        do_load(3'b101, 32'h0000_000C, 32'h0000_F00D);
        do_load(3'b000, 32'h0000_000C, 32'h0000_000D);
        drain();

        do_sub(3'b000, 32'h0000_000D, 32'h1234_5677, 32'h8BAD_770D);
        do_load(3'b010, 32'h0000_000C, 32'h8BAD_770D);
        drain();

        do_err(1'b1, 3'b001, 32'h0000_000D);
        do_err(1'b0, 3'b010, 32'h0000_000E);
        do_err(1'b0, 3'b010, 32'h0000_1000);
        do_err(1'b0, 3'b011, 32'h0000_000C);
        do_err(1'b1, 3'b100, 32'h0000_000C);
        drain();

        do_load(3'b010, 32'h0000_000C, 32'h8BAD_770D);
        sw_acc = last_acc + 2;
        do_sw(32'h0000_0010, 32'hDEAD_BEEF);
        chk("b2b_accept_cycle", 32'(last_acc), 32'(sw_acc));
        do_load(3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
        drain();

        // Reset while the sub-word store is reading the old word
        req   = 1'b1;
        we    = 1'b1;
        f3    = 3'b000;
        addr  = 32'h0000_000C;
        wdata = 32'h0000_00AA;
        chk("rmw_ready_before", {31'b0, ready}, 32'd1);
        @(negedge clk);
        req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        chk("mid_rst_err", {31'b0, err}, 32'd0);
        chk("mid_rst_wren", {31'b0, mem_wren}, 32'd0);
        chk("mid_rst_rdata", rdata, 32'h0);
        chk("mid_rst_mem_addr", {22'b0, mem_addr}, 32'h0);
        chk("mid_rst_mem_wdata", mem_wdata, 32'h0);
        exp_last = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, ready}, 32'd1);
        chk("post_rst_word3", mem[3], 32'h8BAD_770D);
        do_err(1'b0, 3'b001, 32'h0000_0001);
        do_load(3'b010, 32'h0000_000C, 32'h8BAD_770D);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
Load/store unit sitting directly upstream of the word-wide data memory (10-bit word address, combinational read, write on posedge clk_i, word-only write enable). Converts CPU byte/half/word load/store requests (RV32I funct3 encoding) into word accesses. Performs sign/zero extension for loads and a read-modify-write sequence for sub-word stores. Flags misaligned, out-of-range and illegal requests.

Parameters:
MEM_AW, 10, data memory word-address width; byte range is 0 .. 2^(MEM_AW+2)-1.
XLEN, 32, data/address width.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
lsu_req_i  in  1  request valid; accepted when lsu_req_i && lsu_ready_o
lsu_we_i  in  1  1 = store, 0 = load
lsu_funct3_i  in  3  RV32I size/sign code
lsu_addr_i  in  XLEN  byte address
lsu_wdata_i  in  XLEN  store data, right-aligned
lsu_ready_o  out  1  high only in IDLE
lsu_rvalid_o  out  1  one-cycle pulse: load data valid
lsu_rdata_o  out  XLEN  extended load data, registered
lsu_done_o  out  1  one-cycle pulse: store committed
lsu_err_o  out  1  one-cycle pulse: request rejected
mem_addr_o  out  MEM_AW  word address to data memory
mem_wdata_o  out  XLEN  word write data
mem_wren_o  out  1  word write enable
mem_rdata_i  in  XLEN  combinational read data from memory

Behaviour:
- Reset (async, rst_ni low): state IDLE. lsu_rvalid_o, lsu_done_o, lsu_err_o, mem_wren_o = 0. lsu_rdata_o, mem_addr_o, mem_wdata_o = 0. All latched request fields = 0.
- Accept in IDLE: latch we, funct3, addr, wdata. mem_addr_o is driven from latched addr[MEM_AW+1:2].
- Legal funct3, loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal funct3, stores: 000 SB, 001 SH, 010 SW. Any other funct3 is illegal.
- Error checks at accept:
  - halfword with addr[0] != 0;
  - word with addr[1:0] != 0;
  - addr[XLEN-1:MEM_AW+2] != 0;
  - illegal funct3.
  On any error: go to ERR and take no memory action.
- States and transitions:
  - IDLE: ready = 1. Error -> ERR; load -> LOAD; SW -> WRITE; SB/SH -> RMW_RD.
  - LOAD: mem_addr_o held. At the exiting edge, capture the extracted and extended byte/half/word of mem_rdata_i into lsu_rdata_o. Pulse lsu_rvalid_o for the following cycle. -> IDLE.
  - WRITE: mem_wren_o = 1, mem_wdata_o = latched wdata. -> IDLE, lsu_done_o pulses next cycle.
  - RMW_RD: capture mem_rdata_i into merge register, overwriting only the target lane(s):
    - byte lane addr[1:0] <- wdata[7:0];
    - half lane addr[1] <- wdata[15:0].
    -> RMW_WR.
  - RMW_WR: mem_wren_o = 1, mem_wdata_o = merge register. -> IDLE, lsu_done_o pulses next cycle.
  - ERR: -> IDLE, lsu_err_o pulses next cycle.
- mem_wren_o is a pure decode of state, so it drops immediately on reset. It is high for exactly one cycle per store.
- Latency from the accept edge:
  - LW/LB/etc.: rvalid 2 cycles after accept.
  - SW: done 2 cycles after accept.
  - SB/SH: done 3 cycles after accept.
  - Error: err 2 cycles after accept.
- The response pulse cycle coincides with IDLE, so back-to-back requests are allowed in that cycle.
- lsu_rdata_o holds its value until the next load completes. Stores and errors do not change it.
- lsu_req_i while not ready is ignored; the CPU must hold the request.
- Reset mid-RMW: the sequence is abandoned and the memory word is unchanged (the write only occurs in RMW_WR).
- The data memory returns 0 while in reset; the unit never samples memory during reset.

Decomposition:
- Package lsu_pkg:
  - funct3 enum (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum (IDLE, LOAD, WRITE, RMW_RD, RMW_WR, ERR);
  - size decode function.
- Sub-module lsu_byte_lane (combinational):
  - load extract/extend: word, offset, funct3 -> XLEN;
  - store merge: old word, wdata, offset, funct3 -> XLEN.

Test Plan:
Memory preload: word 3 (byte 0x00C) = 0x8BADF00D.
- LW 0x00C -> rvalid 2 cycles after accept, rdata 0x8BADF00D; mem_wren_o never high.
- LB 0x00F -> 0xFFFFFF8B; LBU 0x00F -> 0x0000008B; LH 0x00E -> 0xFFFF8BAD; LHU 0x00C -> 0x0000F00D.
- SB 0x00D wdata 0x12345677 -> one mem_wren_o cycle with wdata 0x8BAD770D; done at accept+3; subsequent LW 0x00C -> 0x8BAD770D.
- SH 0x00D, LW 0x00E, LW 0x1000, funct3 011 -> each: err pulse at accept+2, no wren, no rvalid/done, rdata unchanged.
- SW 0x010 0xDEADBEEF accepted in the same cycle as the previous rvalid pulse -> done at accept+2; LW 0x010 -> 0xDEADBEEF.
- rst_ni low during RMW_RD of SB 0x00C 0xAA -> all outputs 0 immediately, wren never asserted, word 3 unchanged, ready high after release.
